// File: rtl/ifu_prefetch.sv
// ifu_prefetch: instruction fetch unit with a prefetch queue and branch resolution.
//
// Keeps the fetch PC (fpc) and issues one outstanding request at a time on the
// instruction-memory port. Returned words are buffered in a DEPTH-entry circular
// queue that feeds decode. Control-flow results from execute are resolved here.
// A taken branch or jump flushes the queue and restarts fetching at the target.
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   imem_req/imem_addr       fetch request and word-aligned fetch address
//   imem_ack/imem_rdata      acceptance and same-cycle instruction data
//   out_valid/out_ready      queue head handshake towards decode
//   out_inst/out_pc          head instruction and its PC
//   res_valid, res_pc        execute reports a control-flow instruction
//   is_branch/is_jmp/jmp_reg instruction class (jmp_reg = JALR)
//   eq/lt/ltu, fn3           comparator results and branch funct3
//   alu_out/b_imm/j_imm      JALR target, B offset, J offset
//   flush                    combinational redirect, kills younger stages
module ifu_prefetch #(
  parameter int unsigned          XLEN     = 32,
  parameter int unsigned          DEPTH    = 4,
  parameter logic [XLEN-1:0]      RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_pc,
  input  logic            res_valid,
  input  logic [XLEN-1:0] res_pc,
  input  logic            is_branch,
  input  logic            is_jmp,
  input  logic            jmp_reg,
  input  logic            eq,
  input  logic            lt,
  input  logic            ltu,
  input  logic [2:0]      fn3,
  input  logic [XLEN-1:0] alu_out,
  input  logic [XLEN-1:0] b_imm,
  input  logic [XLEN-1:0] j_imm,
  output logic            flush
);

  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [XLEN-1:0] fpc;
  logic [XLEN-1:0] hold_addr;     // address of a request whose data will be dropped
  logic            pend_discard;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic [31:0]     q_inst [DEPTH];
  logic [XLEN-1:0] q_pc   [DEPTH];

  logic            cond;
  logic            redirect;
  logic [XLEN-1:0] target_raw;
  logic [XLEN-1:0] target;
  logic            fire;
  logic            enq;
  logic            deq;

  // Branch condition decode; reserved funct3 encodings never take.
  always_comb begin
    cond = 1'b0;
    case (fn3)
      3'b000:  cond = eq;
      3'b001:  cond = !eq;
      3'b100:  cond = lt;
      3'b101:  cond = !lt;
      3'b110:  cond = ltu;
      3'b111:  cond = !ltu;
      default: cond = 1'b0;
    endcase
  end

  // Redirect decision and target address; jumps win over branches.
  always_comb begin
    target_raw = res_pc + b_imm;
    if (is_jmp) begin
      if (jmp_reg) begin
        target_raw = alu_out;
      end else begin
        target_raw = res_pc + j_imm;
      end
    end else begin
      target_raw = res_pc + b_imm;
    end
    target   = target_raw & {{(XLEN-2){1'b1}}, 2'b00};
    redirect = res_valid & (is_jmp | (is_branch & cond));
    flush    = redirect;
  end

  // Memory port, queue handshake and head outputs.
  always_comb begin
    // A discarded request must still complete, so it stays asserted even when full.
    imem_req  = !rst & ((count < FULL) | pend_discard);
    imem_addr = RESET_PC;
    if (rst) begin
      imem_addr = RESET_PC;
    end else if (pend_discard) begin
      imem_addr = hold_addr;
    end else begin
      imem_addr = fpc;
    end
    fire      = imem_req & imem_ack;
    enq       = fire & !pend_discard & !redirect;
    out_valid = !rst & (count != '0);
    deq       = out_valid & out_ready;
    out_inst  = rst ? 32'd0 : q_inst[rd_ptr];
    out_pc    = rst ? '0    : q_pc[rd_ptr];
  end

  // Fetch PC, discard tracking and prefetch queue state.
  always_ff @(posedge clk) begin
    if (rst) begin
      fpc          <= RESET_PC;
      hold_addr    <= RESET_PC;
      pend_discard <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        q_inst[i] <= 32'd0;
        q_pc[i]   <= '0;
      end
    end else if (redirect) begin
      fpc          <= target;
      hold_addr    <= imem_addr;
      // Only an unacknowledged request needs its later data dropped.
      pend_discard <= imem_req & !imem_ack;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
    end else begin
      if (fire && !pend_discard) begin
        fpc <= fpc + XLEN'(32'd4);
      end
      pend_discard <= pend_discard & !fire;
      if (enq) begin
        q_inst[wr_ptr] <= imem_rdata;
        q_pc[wr_ptr]   <= imem_addr;
        wr_ptr         <= wr_ptr + AW'(1'b1);
      end
      if (deq) begin
        rd_ptr <= rd_ptr + AW'(1'b1);
      end
      case ({enq, deq})
        2'b10:   count <= count + (AW+1)'(1'b1);
        2'b01:   count <= count - (AW+1)'(1'b1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_prefetch.sv
// Testbench for ifu_prefetch: directed stimulus, a queue-based reference model
// checked every cycle, plus literal expectations at key points.
module tb_ifu_prefetch;
  localparam int          XLEN  = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0100;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        res_valid;
  logic [31:0] res_pc;
  logic        is_branch;
  logic        is_jmp;
  logic        jmp_reg;
  logic        eq;
  logic        lt;
  logic        ltu;
  logic [2:0]  fn3;
  logic [31:0] alu_out;
  logic [31:0] b_imm;
  logic [31:0] j_imm;
  logic        flush;

  ifu_prefetch #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .res_valid(res_valid), .res_pc(res_pc), .is_branch(is_branch), .is_jmp(is_jmp),
    .jmp_reg(jmp_reg), .eq(eq), .lt(lt), .ltu(ltu), .fn3(fn3),
    .alu_out(alu_out), .b_imm(b_imm), .j_imm(j_imm), .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: a fixed function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mq[$];   // PCs currently held in the prefetch queue, head first
  logic [31:0] m_fpc;
  logic [31:0] m_hold;
  bit          m_disc;
  bit          chk_en = 1'b0;

  function automatic bit m_taken(input logic [2:0] f, input bit e, input bit l, input bit u);
    bit base;
    if (f[2:1] == 2'b01) return 1'b0;
    base = f[2] ? (f[1] ? u : l) : e;
    return base ^ f[0];
  endfunction

  function automatic bit m_redirect();
    return res_valid && (is_jmp || (is_branch && m_taken(fn3, eq, lt, ltu)));
  endfunction

  function automatic logic [31:0] m_target();
    logic [31:0] t;
    if (is_jmp && jmp_reg) t = alu_out;
    else if (is_jmp)       t = res_pc + j_imm;
    else                   t = res_pc + b_imm;
    return t & ~32'd3;
  endfunction

  function automatic bit m_req();
    return !rst && (mq.size() < DEPTH || m_disc);
  endfunction

  function automatic logic [31:0] m_addr();
    if (rst) return RPC;
    return m_disc ? m_hold : m_fpc;
  endfunction

  always @(posedge clk) begin
    bit          req;
    bit          redir;
    logic [31:0] a;
    req   = m_req();
    a     = m_addr();
    redir = m_redirect();
    if (rst) begin
      mq.delete();
      m_fpc  = RPC;
      m_hold = RPC;
      m_disc = 1'b0;
    end else begin
      if (mq.size() > 0 && out_ready) void'(mq.pop_front());
      if (redir) begin
        mq.delete();
        m_fpc  = m_target();
        m_hold = a;
        m_disc = req && !imem_ack;
      end else if (req && imem_ack) begin
        if (m_disc) begin
          m_disc = 1'b0;
        end else begin
          mq.push_back(a);
          m_fpc = m_fpc + 32'd4;
        end
      end
    end
  end

  // Compare process: DUT outputs against the model, mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_imem_req",  32'(imem_req),  32'(m_req()));
      chk("m_imem_addr", imem_addr,      m_addr());
      chk("m_out_valid", 32'(out_valid), 32'(!rst && mq.size() > 0));
      chk("m_flush",     32'(flush),     32'(m_redirect()));
      if (rst) begin
        chk("m_rst_inst", out_inst, 32'd0);
        chk("m_rst_pc",   out_pc,   32'd0);
      end else if (mq.size() > 0) begin
        chk("m_out_pc",   out_pc,   mq[0]);
        chk("m_out_inst", out_inst, mem_word(mq[0]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_res();
    res_valid = 1'b0; is_branch = 1'b0; is_jmp = 1'b0; jmp_reg = 1'b0;
    eq = 1'b0; lt = 1'b0; ltu = 1'b0; fn3 = 3'b000;
    res_pc = 32'd0; alu_out = 32'd0; b_imm = 32'd0; j_imm = 32'd0;
  endtask

  // {fn3, eq, lt, ltu, expected_taken}
  logic [6:0] btab [9] = '{7'b000_100_1, 7'b000_000_0, 7'b001_100_0, 7'b100_010_1,
                           7'b101_010_0, 7'b110_001_1, 7'b111_000_1, 7'b010_111_0,
                           7'b011_111_0};

  initial begin
    int          n_acks;
    logic [6:0]  v;
    logic [31:0] held;
    rst = 1'b1; imem_ack = 1'b0; out_ready = 1'b0;
    clr_res();
    step();
    chk_en = 1'b1;

    // Reset state
    #1;
    chk("rst_req",   32'(imem_req),  32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_addr",  imem_addr,      RPC);
    chk("rst_inst",  out_inst,       32'd0);
    step();

    // Sequential fetch, zero-wait memory
    rst = 1'b0; imem_ack = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (k == 0) begin
        chk("seq_req",    32'(imem_req),  32'd1);
        chk("seq_addr",   imem_addr,      RPC);
        chk("seq_valid0", 32'(out_valid), 32'd0);
      end else begin
        chk("seq_valid", 32'(out_valid), 32'd1);
        chk("seq_pc",    out_pc,         RPC + 32'(4 * (k - 1)));
      end
      step();
    end

    // Backpressure: queue fills, then drains in order
    rst = 1'b1; step();
    rst = 1'b0; out_ready = 1'b0;
    n_acks = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (imem_req && imem_ack) n_acks++;
      step();
    end
    #1;
    chk("bp_acks",    32'(n_acks),   32'd4);
    chk("bp_req_low", 32'(imem_req), 32'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("bp_pc", out_pc, RPC + 32'(4 * k));
      step();
    end

    // Taken BNE (ack coincides with the redirect)
    res_valid = 1'b1; is_branch = 1'b1; fn3 = 3'b001; eq = 1'b0;
    res_pc = 32'h200; b_imm = 32'hFFFF_FFF0;
    #1; chk("bne_flush", 32'(flush), 32'd1);
    step(); clr_res();
    #1;
    chk("bne_empty", 32'(out_valid), 32'd0);
    chk("bne_addr",  imem_addr,      32'h1F0);
    chk("bne_req",   32'(imem_req),  32'd1);
    step();
    #1; chk("bne_head", out_pc, 32'h1F0);
    step();
    // Not-taken BNE: stream continues
    res_valid = 1'b1; is_branch = 1'b1; fn3 = 3'b001; eq = 1'b1;
    res_pc = 32'h200; b_imm = 32'hFFFF_FFF0;
    #1; chk("bnt_flush", 32'(flush), 32'd0);
    step(); clr_res();
    #1;
    chk("bnt_valid", 32'(out_valid), 32'd1);
    chk("bnt_pc",    out_pc,         32'h1F8);
    step();

    // Branch condition table
    for (int i = 0; i < 9; i++) begin
      v = btab[i];
      res_valid = 1'b1; is_branch = 1'b1;
      fn3 = v[6:4]; eq = v[3]; lt = v[2]; ltu = v[1];
      res_pc = 32'h500 + 32'(16 * i); b_imm = 32'd8;
      #1; chk("bcond_flush", 32'(flush), 32'(v[0]));
      step(); clr_res();
      step();
    end

    // JALR with misaligned target
    res_valid = 1'b1; is_jmp = 1'b1; jmp_reg = 1'b1; alu_out = 32'h303; res_pc = 32'h600;
    #1; chk("jalr_flush", 32'(flush), 32'd1);
    step(); clr_res();
    #1; chk("jalr_addr", imem_addr, 32'h300);
    step();
    // JAL wins over a simultaneous branch flag
    res_valid = 1'b1; is_jmp = 1'b1; is_branch = 1'b1; fn3 = 3'b010;
    res_pc = 32'h400; j_imm = 32'h20; b_imm = 32'h80;
    #1; chk("jal_flush", 32'(flush), 32'd1);
    step(); clr_res();
    #1; chk("jal_addr", imem_addr, 32'h420);
    step(); step();

    // Redirect while a request is pending (ack withheld 3 cycles)
    imem_ack = 1'b0;
    #1; held = m_addr();
    step();
    res_valid = 1'b1; is_jmp = 1'b1; res_pc = 32'h700; j_imm = 32'h40;
    #1;
    chk("pend_flush", 32'(flush), 32'd1);
    chk("pend_addr0", imem_addr,  held);
    step(); clr_res();
    #1;
    chk("pend_hold",  imem_addr,      held);
    chk("pend_req",   32'(imem_req),  32'd1);
    chk("pend_empty", 32'(out_valid), 32'd0);
    step();
    imem_ack = 1'b1;
    #1; chk("pend_ack_addr", imem_addr, held);
    step();
    #1;
    chk("pend_tgt",     imem_addr,      32'h740);
    chk("pend_dropped", 32'(out_valid), 32'd0);
    step();
    #1;
    chk("pend_head", out_pc, 32'h740);
    step();

    // Mid-operation reset with a request pending
    out_ready = 1'b0;
    step(); step();
    imem_ack = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk("mr_req0",  32'(imem_req), 32'd0);
    chk("mr_addr0", imem_addr,     RPC);
    step();
    #1;
    chk("mr_valid", 32'(out_valid), 32'd0);
    chk("mr_req",   32'(imem_req),  32'd0);
    rst = 1'b0; imem_ack = 1'b1; out_ready = 1'b1;
    #1;
    chk("mr_restart_req",  32'(imem_req), 32'd1);
    chk("mr_restart_addr", imem_addr,     RPC);
    step();
    #1; chk("mr_restart_pc", out_pc, RPC);
    step(); step(); step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
